// File: rtl/dphy_rx_lane_hs_sequencer.sv
// ---------------------------------------------------------------------------
// dphy_rx_lane_hs_sequencer
//
// LP-to-HS entry/exit sequencer for a 4-lane CSI-2 D-PHY receiver. It watches
// the low-power line states of the clock lane and data lane 0, sequences the
// termination and HS-receiver enables for the clock lane and the data lanes,
// and gates the lane-aligner HS sync. Data-lane HS residency is protected by
// a timeout so a lane stuck in LP00 cannot hold the receiver in HS forever.
//
// Ports:
//   clk_lp_ctrl_i      block clock, all logic on the rising edge
//   reset_i            synchronous reset, active high
//   lp_clk_p_i/_n_i    clock-lane LP receiver outputs (asynchronous)
//   lp_d0_p_i/_n_i     data-lane-0 LP receiver outputs (asynchronous)
//   hs_sync_i          HS sync from the lane aligner
//   term_clk_en_o      clock-lane termination enable
//   term_dN_en_o       data-lane termination enables (N = 0..3)
//   hs_dN_en_o         data-lane HS receiver enables (N = 0..3)
//   hs_sync_o          hs_sync_i qualified by data HS state, registered
//   hs_timeout_o       one-cycle pulse when HS is abandoned for lack of sync
//   lp_hs_state_clk_o  clock FSM state (debug)
//   lp_hs_state_d_o    data FSM state (debug)
//
// Line states are encoded {P,N}: LP11 = 2'b11, LP01 = 2'b01, LP10 = 2'b10,
// LP00 = 2'b00. The FSMs only ever see the 2-flop synchronized copies, so a
// line change moves a state register on the third clock edge after the
// change is first sampled.
// ---------------------------------------------------------------------------
module dphy_rx_lane_hs_sequencer #(
    parameter int NUM_RX_LANE = 4,
    parameter int T_SETTLE    = 6,
    parameter int TD_TERM     = 2,
    parameter int TD_TERM_CLK = 2,
    parameter int HS_TIMEOUT  = 64
) (
    input  logic       clk_lp_ctrl_i,
    input  logic       reset_i,
    input  logic       lp_clk_p_i,
    input  logic       lp_clk_n_i,
    input  logic       lp_d0_p_i,
    input  logic       lp_d0_n_i,
    input  logic       hs_sync_i,
    output logic       term_clk_en_o,
    output logic       term_d0_en_o,
    output logic       term_d1_en_o,
    output logic       term_d2_en_o,
    output logic       term_d3_en_o,
    output logic       hs_d0_en_o,
    output logic       hs_d1_en_o,
    output logic       hs_d2_en_o,
    output logic       hs_d3_en_o,
    output logic       hs_sync_o,
    output logic       hs_timeout_o,
    output logic [1:0] lp_hs_state_clk_o,
    output logic [1:0] lp_hs_state_d_o
);

    // -----------------------------------------------------------------------
    // Line-state encodings and FSM state types
    // -----------------------------------------------------------------------
    localparam logic [1:0] LP00 = 2'b00;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP11 = 2'b11;

    typedef enum logic [1:0] {
        D_IDLE    = 2'b00,
        D_HS_RQST = 2'b01,
        D_SETTLE  = 2'b10,
        D_HS      = 2'b11
    } data_state_e;

    typedef enum logic [1:0] {
        C_IDLE      = 2'b00,
        C_RQST      = 2'b01,
        C_TERM_WAIT = 2'b10,
        C_HS_CLK    = 2'b11
    } clk_state_e;

    // -----------------------------------------------------------------------
    // Counter widths and terminal values. Each counter only has to reach
    // its own "last" value, so it is sized for that value.
    // -----------------------------------------------------------------------
    localparam int SCW = (T_SETTLE > 1)    ? $clog2(T_SETTLE)    : 1;
    localparam int TCW = (HS_TIMEOUT > 1)  ? $clog2(HS_TIMEOUT)  : 1;
    localparam int CCW = (TD_TERM_CLK > 1) ? $clog2(TD_TERM_CLK) : 1;

    localparam logic [SCW-1:0] SETTLE_LAST  = SCW'(T_SETTLE - 1);
    localparam logic [SCW-1:0] SETTLE_ONE   = SCW'(1);
    localparam logic [SCW-1:0] SETTLE_ZERO  = SCW'(0);
    localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(HS_TIMEOUT - 1);
    localparam logic [TCW-1:0] TIMEOUT_ONE  = TCW'(1);
    localparam logic [TCW-1:0] TIMEOUT_ZERO = TCW'(0);
    localparam logic [CCW-1:0] CTERM_LAST   = CCW'(TD_TERM_CLK - 1);
    localparam logic [CCW-1:0] CTERM_ONE    = CCW'(1);
    localparam logic [CCW-1:0] CTERM_ZERO   = CCW'(0);

    // Termination turns on at the edge where cnt becomes TD_TERM, i.e. when
    // the current count is TD_TERM-1. TD_TERM = 0 is handled on SETTLE entry.
    localparam int             TERM_PRE     = (TD_TERM > 0) ? (TD_TERM - 1) : 0;
    localparam logic [SCW-1:0] TERM_PRE_V   = SCW'(TERM_PRE);
    localparam logic           TERM_AT_ENTRY = (TD_TERM == 0);

    // Active-lane mask: lanes at or above NUM_RX_LANE never get an enable.
    function automatic logic [3:0] lane_mask(input int lanes);
        logic [3:0] mask;
        mask = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (i < lanes) begin
                mask[i] = 1'b1;
            end else begin
                mask[i] = 1'b0;
            end
        end
        return mask;
    endfunction

    localparam logic [3:0] LANE_MASK = lane_mask(NUM_RX_LANE);

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    logic [1:0]     lp_clk_meta_r;
    logic [1:0]     lp_clk_sync_r;
    logic [1:0]     lp_d_meta_r;
    logic [1:0]     lp_d_sync_r;

    data_state_e    state_d_r;
    logic [SCW-1:0] cnt_r;
    logic [TCW-1:0] tcnt_r;
    logic           armed_r;
    logic           got_sync_r;
    logic [3:0]     term_d_r;
    logic [3:0]     hs_d_r;
    logic           hs_timeout_r;
    logic           hs_sync_r;

    clk_state_e     state_clk_r;
    logic [CCW-1:0] ccnt_r;
    logic           term_clk_r;

    // 2-flop synchronizers for the asynchronous LP receiver outputs
    always_ff @(posedge clk_lp_ctrl_i) begin
        if (reset_i) begin
            lp_clk_meta_r <= 2'b00;
            lp_clk_sync_r <= 2'b00;
            lp_d_meta_r   <= 2'b00;
            lp_d_sync_r   <= 2'b00;
        end else begin
            lp_clk_meta_r <= {lp_clk_p_i, lp_clk_n_i};
            lp_clk_sync_r <= lp_clk_meta_r;
            lp_d_meta_r   <= {lp_d0_p_i, lp_d0_n_i};
            lp_d_sync_r   <= lp_d_meta_r;
        end
    end

    // Data-lane FSM: LP request, settle timing, HS residency and timeout
    always_ff @(posedge clk_lp_ctrl_i) begin
        if (reset_i) begin
            state_d_r    <= D_IDLE;
            cnt_r        <= SETTLE_ZERO;
            tcnt_r       <= TIMEOUT_ZERO;
            armed_r      <= 1'b0;
            got_sync_r   <= 1'b0;
            term_d_r     <= 4'b0000;
            hs_d_r       <= 4'b0000;
            hs_timeout_r <= 1'b0;
        end else begin
            hs_timeout_r <= 1'b0;

            // Seeing Stop state is what re-arms entry; this also makes LP11
            // win over a simultaneous timeout in HS.
            if (lp_d_sync_r == LP11) begin
                armed_r <= 1'b1;
            end

            case (state_d_r)
                D_IDLE: begin
                    term_d_r <= 4'b0000;
                    hs_d_r   <= 4'b0000;
                    if ((lp_d_sync_r == LP01) && armed_r) begin
                        state_d_r <= D_HS_RQST;
                    end
                end

                D_HS_RQST: begin
                    term_d_r <= 4'b0000;
                    hs_d_r   <= 4'b0000;
                    if (lp_d_sync_r == LP00) begin
                        state_d_r <= D_SETTLE;
                        cnt_r     <= SETTLE_ZERO;
                        term_d_r  <= TERM_AT_ENTRY ? LANE_MASK : 4'b0000;
                    end else if (lp_d_sync_r != LP01) begin
                        state_d_r <= D_IDLE;
                    end
                end

                D_SETTLE: begin
                    hs_d_r <= 4'b0000;
                    if (lp_d_sync_r != LP00) begin
                        // Aborted bridge: back off without any enable left on
                        state_d_r <= D_IDLE;
                        cnt_r     <= SETTLE_ZERO;
                        term_d_r  <= 4'b0000;
                    end else if (cnt_r == SETTLE_LAST) begin
                        state_d_r  <= D_HS;
                        tcnt_r     <= TIMEOUT_ZERO;
                        got_sync_r <= 1'b0;
                        term_d_r   <= LANE_MASK;
                        hs_d_r     <= LANE_MASK;
                    end else begin
                        cnt_r <= cnt_r + SETTLE_ONE;
                        if (cnt_r >= TERM_PRE_V) begin
                            term_d_r <= LANE_MASK;
                        end
                    end
                end

                D_HS: begin
                    if (lp_d_sync_r == LP11) begin
                        state_d_r  <= D_IDLE;
                        tcnt_r     <= TIMEOUT_ZERO;
                        got_sync_r <= 1'b0;
                        term_d_r   <= 4'b0000;
                        hs_d_r     <= 4'b0000;
                    end else if ((tcnt_r == TIMEOUT_LAST) && !got_sync_r && !hs_sync_i) begin
                        // No sync ever arrived: leave HS disarmed so a stuck
                        // LP00 line cannot re-trigger entry.
                        state_d_r    <= D_IDLE;
                        tcnt_r       <= TIMEOUT_ZERO;
                        armed_r      <= 1'b0;
                        term_d_r     <= 4'b0000;
                        hs_d_r       <= 4'b0000;
                        hs_timeout_r <= 1'b1;
                    end else begin
                        term_d_r <= LANE_MASK;
                        hs_d_r   <= LANE_MASK;
                        if (tcnt_r != TIMEOUT_LAST) begin
                            tcnt_r <= tcnt_r + TIMEOUT_ONE;
                        end
                        if (hs_sync_i) begin
                            got_sync_r <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_d_r <= D_IDLE;
                    term_d_r  <= 4'b0000;
                    hs_d_r    <= 4'b0000;
                end
            endcase
        end
    end

    // Aligner sync is only forwarded while the data lanes are in HS
    always_ff @(posedge clk_lp_ctrl_i) begin
        if (reset_i) begin
            hs_sync_r <= 1'b0;
        end else begin
            hs_sync_r <= hs_sync_i && (state_d_r == D_HS);
        end
    end

    // Clock-lane FSM: request, termination delay, HS clock residency
    always_ff @(posedge clk_lp_ctrl_i) begin
        if (reset_i) begin
            state_clk_r <= C_IDLE;
            ccnt_r      <= CTERM_ZERO;
            term_clk_r  <= 1'b0;
        end else begin
            case (state_clk_r)
                C_IDLE: begin
                    term_clk_r <= 1'b0;
                    if (lp_clk_sync_r == LP01) begin
                        state_clk_r <= C_RQST;
                    end
                end

                C_RQST: begin
                    term_clk_r <= 1'b0;
                    if (lp_clk_sync_r == LP00) begin
                        state_clk_r <= C_TERM_WAIT;
                        ccnt_r      <= CTERM_ZERO;
                    end else if (lp_clk_sync_r != LP01) begin
                        state_clk_r <= C_IDLE;
                    end
                end

                C_TERM_WAIT: begin
                    if (lp_clk_sync_r != LP00) begin
                        state_clk_r <= C_IDLE;
                        ccnt_r      <= CTERM_ZERO;
                        term_clk_r  <= 1'b0;
                    end else if (ccnt_r == CTERM_LAST) begin
                        state_clk_r <= C_HS_CLK;
                        term_clk_r  <= 1'b1;
                    end else begin
                        ccnt_r     <= ccnt_r + CTERM_ONE;
                        term_clk_r <= 1'b0;
                    end
                end

                C_HS_CLK: begin
                    if (lp_clk_sync_r == LP11) begin
                        state_clk_r <= C_IDLE;
                        ccnt_r      <= CTERM_ZERO;
                        term_clk_r  <= 1'b0;
                    end else begin
                        term_clk_r <= 1'b1;
                    end
                end

                default: begin
                    state_clk_r <= C_IDLE;
                    term_clk_r  <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: straight from registers
    // -----------------------------------------------------------------------
    assign term_clk_en_o     = term_clk_r;
    assign term_d0_en_o      = term_d_r[0];
    assign term_d1_en_o      = term_d_r[1];
    assign term_d2_en_o      = term_d_r[2];
    assign term_d3_en_o      = term_d_r[3];
    assign hs_d0_en_o        = hs_d_r[0];
    assign hs_d1_en_o        = hs_d_r[1];
    assign hs_d2_en_o        = hs_d_r[2];
    assign hs_d3_en_o        = hs_d_r[3];
    assign hs_sync_o         = hs_sync_r;
    assign hs_timeout_o      = hs_timeout_r;
    assign lp_hs_state_clk_o = state_clk_r;
    assign lp_hs_state_d_o   = state_d_r;

endmodule

// File: doc/dphy_rx_lane_hs_sequencer.md
Name: dphy_rx_lane_hs_sequencer

Overview:
Single-clock LP-to-HS entry/exit sequencer for a 4-lane CSI-2 D-PHY receiver.
- Watches the LP line states of the clock lane and data lane 0.
- Drives the termination-enable and HS-enable controls for the clock lane and all data lanes.
- Gates the lane-aligner HS sync.
- Sits between the LP receivers and the byte-level rx global control / lane aligner datapath. Replaces the fixed-mode enable logic with timed, timeout-protected sequencing.

Parameters:
NUM_RX_LANE, 4, number of active data lanes (1..4); enables for lanes >= NUM_RX_LANE are tied 0.
T_SETTLE, 6, clk_lp_ctrl_i cycles spent in data SETTLE state (LP00 to HS enable); must be > TD_TERM.
TD_TERM, 2, cycles in SETTLE before data-lane termination is enabled.
TD_TERM_CLK, 2, cycles of clock-lane LP00 before clock termination is enabled.
HS_TIMEOUT, 64, max cycles in data HS state without hs_sync_i before forced exit.

Ports:
clk_lp_ctrl_i  in  1  block clock; all logic on rising edge
reset_i  in  1  synchronous reset, active high
lp_clk_p_i  in  1  clock-lane LP P (asynchronous)
lp_clk_n_i  in  1  clock-lane LP N (asynchronous)
lp_d0_p_i  in  1  data lane 0 LP P (asynchronous)
lp_d0_n_i  in  1  data lane 0 LP N (asynchronous)
hs_sync_i  in  1  HS sync from lane aligner, active high
term_clk_en_o  out  1  clock-lane termination enable
term_d0_en_o .. term_d3_en_o  out  1 each  data-lane termination enables
hs_d0_en_o .. hs_d3_en_o  out  1 each  data-lane HS enables
hs_sync_o  out  1  hs_sync_i gated by data HS state, registered
hs_timeout_o  out  1  one-cycle pulse on HS timeout
lp_hs_state_clk_o  out  2  clock FSM state (debug)
lp_hs_state_d_o  out  2  data FSM state (debug)

Behaviour:
- LP inputs pass through 2-flop synchronizers; the FSMs use only the synchronized values {P,N}.
- An input change moves the state 3 clock edges after it is first sampled.
- All outputs are registered and update on the same edge as the state register.
- Reset: both FSMs go to IDLE (00), counters go to 0, armed=0, and every output is 0. Reset mid-HS drops all enables on the next edge.

Data FSM (lp_hs_state_d_o):
- IDLE 00:
  - LP11 sets armed=1.
  - LP01 with armed=1 -> HS_RQST.
  - LP01 with armed=0 stays in IDLE.
- HS_RQST 01:
  - LP00 -> SETTLE, cnt=0.
  - LP11 or LP10 -> IDLE.
  - LP01 stays.
- SETTLE 10:
  - cnt increments every cycle.
  - term_dN_en_o=1 from the edge where cnt reaches TD_TERM.
  - Leaving SETTLE: cnt==T_SETTLE-1 -> HS. Total SETTLE dwell is exactly T_SETTLE cycles.
  - Any LP state other than 00 -> IDLE with term cleared.
- HS 11:
  - hs_dN_en_o=1 and term_dN_en_o=1 for N<NUM_RX_LANE.
  - tcnt counts from 0; got_sync is set by hs_sync_i.
  - LP11 -> IDLE: enables clear and armed=1.
  - tcnt==HS_TIMEOUT-1 with got_sync=0 and hs_sync_i=0 -> IDLE, armed=0, hs_timeout_o pulses for 1 cycle.
  - If LP11 and the timeout fire in the same cycle, LP11 wins: no pulse, armed=1.
  - With armed=0 the FSM re-enters only after LP11 is seen, so a stuck LP00 cannot loop.
- hs_sync_o = registered (hs_sync_i & state==HS).
- Counters saturate and never wrap.

Clock FSM (lp_hs_state_clk_o):
- IDLE 00: LP01 -> RQST.
- RQST 01: LP00 -> TERM_WAIT with ccnt=0; LP11/LP10 -> IDLE.
- TERM_WAIT 10: ccnt==TD_TERM_CLK-1 -> HS_CLK; non-00 -> IDLE.
- HS_CLK 11: term_clk_en_o=1; LP11 -> IDLE and clear.
- The clock FSM is independent of the data FSM and has no armed gating.

Test Plan:
1. Reset held 3 cycles with LP11 on all inputs -> all outputs 0, both states 00; armed=1 observable 3 cycles after release.
2. Data lane LP11 -> LP01 -> LP00 (held) -> lp_hs_state_d_o goes 01, 10, 11.
   - term_d0..3_en_o rise 2 cycles after SETTLE entry.
   - hs_dN_en_o rises 6 cycles after SETTLE entry.
   - LP11 then drops both enables 3 cycles later.
3. NUM_RX_LANE=2, same stimulus -> term_d2/d3_en_o and hs_d2/d3_en_o stay 0 throughout.
4. HS entered, hs_sync_i never asserted, LP00 held -> after exactly 64 HS cycles hs_timeout_o pulses once.
   - State returns to 00 and stays there despite LP00/LP01.
   - Re-entry only after LP11 then LP01.
5. LP01 glitch to LP10 in HS_RQST, and LP01 glitch in SETTLE -> state returns to 00 with no term/hs enable ever asserted.
6. Clock lane LP11 -> LP01 -> LP00 -> term_clk_en_o rises 2 cycles after TERM_WAIT entry.
   - Data-lane outputs are unaffected.
   - Reset asserted mid-HS_CLK clears term_clk_en_o on the next edge.
